// File: rtl/core_decode_if.sv
// Fetch-side and issue-side handshake bundle of the RV32I decode stage.
// The decoded operation flags travel here as individual one-bit signals.
interface core_decode_if #(
   parameter int PC_W = 32
);
   logic            flush;
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_inst;
   logic [PC_W-1:0] in_pc;
   logic            out_valid;
   logic            out_ready;
   logic [PC_W-1:0] out_pc;
   logic [4:0]      RS1_ADDR;
   logic [4:0]      RS2_ADDR;
   logic [4:0]      RD_ADDR;
   logic [31:0]     IMM;
   logic I_ADDI, I_SLTI, I_SLTIU, I_XORI, I_ORI, I_ANDI;
   logic I_SLLI, I_SRLI, I_SRAI;
   logic I_ADD, I_SUB, I_SLL, I_SLT, I_SLTU;
   logic I_XOR, I_SRL, I_SRA, I_OR, I_AND;
   logic I_BEQ, I_BNE, I_BLT, I_BGE, I_BLTU, I_BGEU;
   logic I_LB, I_LH, I_LW, I_LBU, I_LHU;
   logic I_SB, I_SH, I_SW;
   logic            out_illegal;

   modport master (
      output flush, in_valid, in_inst, in_pc, out_ready,
      input  in_ready, out_valid, out_pc,
      input  RS1_ADDR, RS2_ADDR, RD_ADDR, IMM, out_illegal,
      input  I_ADDI, I_SLTI, I_SLTIU, I_XORI, I_ORI, I_ANDI,
      input  I_SLLI, I_SRLI, I_SRAI,
      input  I_ADD, I_SUB, I_SLL, I_SLT, I_SLTU,
      input  I_XOR, I_SRL, I_SRA, I_OR, I_AND,
      input  I_BEQ, I_BNE, I_BLT, I_BGE, I_BLTU, I_BGEU,
      input  I_LB, I_LH, I_LW, I_LBU, I_LHU,
      input  I_SB, I_SH, I_SW
   );

   modport slave (
      input  flush, in_valid, in_inst, in_pc, out_ready,
      output in_ready, out_valid, out_pc,
      output RS1_ADDR, RS2_ADDR, RD_ADDR, IMM, out_illegal,
      output I_ADDI, I_SLTI, I_SLTIU, I_XORI, I_ORI, I_ANDI,
      output I_SLLI, I_SRLI, I_SRAI,
      output I_ADD, I_SUB, I_SLL, I_SLT, I_SLTU,
      output I_XOR, I_SRL, I_SRA, I_OR, I_AND,
      output I_BEQ, I_BNE, I_BLT, I_BGE, I_BLTU, I_BGEU,
      output I_LB, I_LH, I_LW, I_LBU, I_LHU,
      output I_SB, I_SH, I_SW
   );
endinterface

// File: rtl/core_decode.sv
// RV32I decode stage: one registered output slot with valid/ready,
// one-hot operation flags, register addresses and immediate.
module core_decode #(
   parameter int PC_W = 32
) (
   input logic         clk,
   input logic         rst_n,
   core_decode_if.slave d
);

   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] OP_REG = 7'b0110011;
   localparam logic [6:0] OP_BR  = 7'b1100011;
   localparam logic [6:0] OP_LD  = 7'b0000011;
   localparam logic [6:0] OP_ST  = 7'b0100011;

   logic [6:0]  opc;
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic [31:0] inst;

   // flag bit order: 0-18 ALU, 19-24 branch, 25-29 load, 30-32 store
   logic [32:0] flags_d;
   logic [31:0] imm_d;
   logic [4:0]  rd_d;

   logic            valid_q;
   logic            ill_q;
   logic [32:0]     flags_q;
   logic [31:0]     imm_q;
   logic [PC_W-1:0] pc_q;
   logic [4:0]      rs1_q;
   logic [4:0]      rs2_q;
   logic [4:0]      rd_q;

   logic accept;
   logic pop;

   assign inst = d.in_inst;
   assign opc  = inst[6:0];
   assign f3   = inst[14:12];
   assign f7   = inst[31:25];

   always_comb begin
      flags_d = '0;
      imm_d   = '0;
      rd_d    = inst[11:7];
      unique case (1'b1)
         (opc == OP_IMM): begin
            case (f3)
               3'b000: flags_d[0] = 1'b1;
               3'b010: flags_d[1] = 1'b1;
               3'b011: flags_d[2] = 1'b1;
               3'b100: flags_d[3] = 1'b1;
               3'b110: flags_d[4] = 1'b1;
               3'b111: flags_d[5] = 1'b1;
               3'b001: flags_d[6] = (f7 == 7'h00);
               default: begin
                  flags_d[7] = (f7 == 7'h00);
                  flags_d[8] = (f7 == 7'h20);
               end
            endcase
            if (f3[1:0] == 2'b01)
               imm_d = {27'b0, inst[24:20]};
            else
               imm_d = {{20{inst[31]}}, inst[31:20]};
         end
         (opc == OP_REG): begin
            if (f7 == 7'h00) begin
               case (f3)
                  3'b000: flags_d[9]  = 1'b1;
                  3'b001: flags_d[11] = 1'b1;
                  3'b010: flags_d[12] = 1'b1;
                  3'b011: flags_d[13] = 1'b1;
                  3'b100: flags_d[14] = 1'b1;
                  3'b101: flags_d[15] = 1'b1;
                  3'b110: flags_d[17] = 1'b1;
                  default: flags_d[18] = 1'b1;
               endcase
            end else if (f7 == 7'h20) begin
               flags_d[10] = (f3 == 3'b000);
               flags_d[16] = (f3 == 3'b101);
            end
         end
         (opc == OP_BR): begin
            case (f3)
               3'b000: flags_d[19] = 1'b1;
               3'b001: flags_d[20] = 1'b1;
               3'b100: flags_d[21] = 1'b1;
               3'b101: flags_d[22] = 1'b1;
               3'b110: flags_d[23] = 1'b1;
               3'b111: flags_d[24] = 1'b1;
               default: ;
            endcase
            imm_d = {{20{inst[31]}}, inst[7], inst[30:25],
                     inst[11:8], 1'b0};
            rd_d  = '0;
         end
         (opc == OP_LD): begin
            case (f3)
               3'b000: flags_d[25] = 1'b1;
               3'b001: flags_d[26] = 1'b1;
               3'b010: flags_d[27] = 1'b1;
               3'b100: flags_d[28] = 1'b1;
               3'b101: flags_d[29] = 1'b1;
               default: ;
            endcase
            imm_d = {{20{inst[31]}}, inst[31:20]};
         end
         (opc == OP_ST): begin
            case (f3)
               3'b000: flags_d[30] = 1'b1;
               3'b001: flags_d[31] = 1'b1;
               3'b010: flags_d[32] = 1'b1;
               default: ;
            endcase
            imm_d = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            rd_d  = '0;
         end
         default: ;
      endcase
      // an unrecognised encoding leaves no flag set
      if (flags_d == '0)
         imm_d = '0;
   end

   assign d.in_ready = !valid_q || d.out_ready;
   assign accept     = d.in_valid && d.in_ready;
   assign pop        = valid_q && d.out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         ill_q   <= 1'b0;
         flags_q <= '0;
         imm_q   <= '0;
         pc_q    <= '0;
         rs1_q   <= '0;
         rs2_q   <= '0;
         rd_q    <= '0;
      end else if (d.flush) begin
         valid_q <= 1'b0;
         ill_q   <= 1'b0;
         flags_q <= '0;
      end else if (accept) begin
         valid_q <= 1'b1;
         ill_q   <= (flags_d == '0);
         flags_q <= flags_d;
         imm_q   <= imm_d;
         pc_q    <= d.in_pc;
         rs1_q   <= inst[19:15];
         rs2_q   <= inst[24:20];
         rd_q    <= rd_d;
      end else if (pop) begin
         valid_q <= 1'b0;
         ill_q   <= 1'b0;
         flags_q <= '0;
      end
   end

   assign d.out_valid   = valid_q;
   assign d.out_illegal = ill_q;
   assign d.out_pc      = pc_q;
   assign d.RS1_ADDR    = rs1_q;
   assign d.RS2_ADDR    = rs2_q;
   assign d.RD_ADDR     = rd_q;
   assign d.IMM         = imm_q;

   assign {d.I_SW, d.I_SH, d.I_SB,
           d.I_LHU, d.I_LBU, d.I_LW, d.I_LH, d.I_LB,
           d.I_BGEU, d.I_BLTU, d.I_BGE, d.I_BLT, d.I_BNE, d.I_BEQ,
           d.I_AND, d.I_OR, d.I_SRA, d.I_SRL, d.I_XOR,
           d.I_SLTU, d.I_SLT, d.I_SLL, d.I_SUB, d.I_ADD,
           d.I_SRAI, d.I_SRLI, d.I_SLLI,
           d.I_ANDI, d.I_ORI, d.I_XORI, d.I_SLTIU, d.I_SLTI,
           d.I_ADDI} = flags_q;

endmodule
